// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator answering host start pulses; DHT_RESP_CKSUM_ERR_EN adds cksum_err to invert the checksum
module dht11_responder #(
  parameter int CLK_FREQ      = 12000000,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  inout  wire         dht_data,
  input  logic [31:0] payload,
`ifdef DHT_RESP_CKSUM_ERR_EN
  input  logic        cksum_err,
`endif
  output logic        busy,
  output logic        frame_done,
  output logic [3:0]  debug_state
);
  localparam int DIV = CLK_FREQ / 1000000;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [3:0] {IDLE, START_LOW, WAIT_REL, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW} state_t;
  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          din_s;
  logic [PW-1:0] pre_q, pre_d;
  logic          us_tick;
  logic [14:0]   us_cnt_q, us_cnt_d, target;
  logic          phase_end;
  logic [39:0]   sr_q, sr_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic          busy_q, busy_d, done_q, done_d, drive_q, armed_q, armed_d;
  logic [7:0]    cksum;
  assign din_s       = sync_q[1];
  assign us_tick     = pre_q == PW'(DIV - 1);
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign debug_state = state_q;
  assign dht_data    = drive_q ? 1'b0 : 1'bz;
`ifdef DHT_RESP_CKSUM_ERR_EN
  assign cksum = (payload[31:24] + payload[23:16] + payload[15:8] + payload[7:0]) ^ {8{cksum_err}};
`else
  assign cksum = payload[31:24] + payload[23:16] + payload[15:8] + payload[7:0];
`endif
  // next state: phase lengths in microseconds, one phase per state; armed blocks re-triggering on our own trailing low
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    armed_d   = armed_q | din_s;
    target    = state_q == WAIT_REL ? 15'(RESP_DELAY_US) :
                (state_q == RESP_LOW || state_q == RESP_HIGH) ? 15'd80 :
                state_q == BIT_HIGH ? (sr_q[39] ? 15'd70 : 15'd26) : 15'd50;
    phase_end = us_tick && us_cnt_q == target - 15'd1;
    case (state_q)
      IDLE:      if (armed_q && !din_s) state_d = START_LOW;
      START_LOW: if (din_s) state_d = us_cnt_q >= 15'(START_MIN_US) ? WAIT_REL : IDLE;
      WAIT_REL:  if (phase_end) begin
        sr_d      = {payload, cksum};
        bit_cnt_d = '0;
        busy_d    = 1'b1;
        state_d   = RESP_LOW;
      end
      RESP_LOW:  if (phase_end) state_d = RESP_HIGH;
      RESP_HIGH: if (phase_end) state_d = BIT_LOW;
      BIT_LOW:   if (phase_end) state_d = BIT_HIGH;
      BIT_HIGH:  if (phase_end) begin
        sr_d      = {sr_q[38:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 6'd1;
        state_d   = bit_cnt_q == 6'd39 ? END_LOW : BIT_LOW;
      end
      END_LOW:   if (phase_end) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        armed_d = 1'b0;
        state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
    pre_d    = (state_d != state_q || us_tick) ? '0 : pre_q + PW'(1);
    us_cnt_d = state_d != state_q ? '0 : (us_tick && us_cnt_q != '1) ? us_cnt_q + 15'd1 : us_cnt_q;
  end
  // state, timebase and bus driver registers; reset releases the bus immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      pre_q     <= '0;
      us_cnt_q  <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drive_q   <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], dht_data};
      pre_q     <= pre_d;
      us_cnt_q  <= us_cnt_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drive_q   <= state_d == RESP_LOW || state_d == BIT_LOW || state_d == END_LOW;
      armed_q   <= armed_d;
    end
  end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: randomized host reads decoded from bus pulse widths and checked against a payload/checksum model
module tb_dht11_responder;
  localparam int CLK_FREQ   = 2000000;
  localparam int DIV        = 2;
  localparam int START_MIN  = 200;
  localparam int RESP_DELAY = 30;
  logic clk = 1'b0, reset_n = 1'b0, host_low = 1'b0, cksum_err = 1'b0;
  logic [31:0] payload = '0;
  logic busy, frame_done;
  logic [3:0] debug_state;
  wire dht_data;
  int total = 0, bad = 0, fd_count = 0, run_len = 0;
  int runs_len[$];
  logic runs_lvl[$];
  logic lvl_q = 1'b1, in_frame = 1'b0, seen_low = 1'b0;
  pullup (dht_data);
  assign dht_data = host_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  dht11_responder #(.CLK_FREQ(CLK_FREQ), .START_MIN_US(START_MIN), .RESP_DELAY_US(RESP_DELAY)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .dht_data(dht_data),
    .payload(payload),
`ifdef DHT_RESP_CKSUM_ERR_EN
    .cksum_err(cksum_err),
`endif
    .busy(busy),
    .frame_done(frame_done),
    .debug_state(debug_state)
  );
  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // the sensor view of a frame: payload bytes MSB first, then their 8-bit sum
  function automatic logic [39:0] model_word(input logic [31:0] p, input logic err);
    logic [7:0] s;
    s = p[31:24] + p[23:16] + p[15:8] + p[7:0];
    return {p, err ? ~s : s};
  endfunction
  // bus run-length recorder and per-cycle busy/quiet compare
  always @(negedge clk) begin
    logic dut_low;
    if (dht_data !== lvl_q) begin
      runs_len.push_back(run_len);
      runs_lvl.push_back(lvl_q);
      lvl_q = dht_data;
      run_len = 1;
    end else run_len++;
    if (frame_done === 1'b1) fd_count++;
    dut_low = dht_data === 1'b0 && !host_low;
    if (in_frame) begin
      if (dut_low) seen_low = 1'b1;
      check(busy === (seen_low && !frame_done), "busy", busy, seen_low && !frame_done);
      if (frame_done === 1'b1) in_frame = 1'b0;
    end else
      check({busy, frame_done, dut_low} === 3'b000, "quiet", {busy, frame_done, dut_low}, 0);
  end
  task automatic host_start(input int us);
    @(posedge clk); #1 host_low = 1'b1;
    repeat (us * DIV) @(posedge clk);
    #1 host_low = 1'b0;
  endtask
  task automatic begin_frame(input logic [31:0] pl, output int fd0);
    repeat (10) @(posedge clk);
    payload = pl;
    host_start(START_MIN + 3);
    in_frame = 1'b1;
    seen_low = 1'b0;
    @(negedge clk); #1;
    runs_len.delete();
    runs_lvl.delete();
    fd0 = fd_count;
  endtask
  task automatic run_frame(input logic [31:0] pl, input logic [39:0] exp_word);
    int fd0, t;
    logic [39:0] got;
    begin_frame(pl, fd0);
    t = 0;
    while (!busy && t < 2000) begin @(negedge clk); t++; end
    payload = $urandom;
    t = 0;
    while (fd_count == fd0 && t < 20000) begin @(negedge clk); t++; end
    if (fd_count == fd0) begin
      check(0, "frame_timeout", t, 20000);
      in_frame = 1'b0;
      reset_n = 1'b0; repeat (3) @(posedge clk); #1 reset_n = 1'b1;
      return;
    end
    repeat (20) @(negedge clk);
    check(fd_count - fd0 == 1, "frame_done_once", fd_count - fd0, 1);
    check(runs_len.size() == 84, "nphase", runs_len.size(), 84);
    if (runs_len.size() == 84) begin
      got = '0;
      for (int i = 0; i < 84; i++) begin
        int e, tol;
        logic l;
        l = i % 2 == 0;
        tol = i == 0 ? DIV + 3 : DIV;
        e = i == 0 ? RESP_DELAY * DIV : i < 3 ? 80 * DIV : !l ? 50 * DIV : (exp_word[39 - (i - 4) / 2] ? 70 : 26) * DIV;
        check(runs_lvl[i] == l && runs_len[i] >= e - tol && runs_len[i] <= e + tol,
              $sformatf("phase%0d", i), runs_len[i], e);
      end
      for (int k = 0; k < 40; k++) got[39 - k] = runs_len[4 + 2 * k] > 48 * DIV;
      check(got === exp_word, "word", got, exp_word);
    end
  endtask
  initial begin
    int fd0, t;
    logic [31:0] p;
    #1;
    check(busy === 1'b0, "rst_busy", busy, 0);
    check(frame_done === 1'b0, "rst_done", frame_done, 0);
    check(dht_data === 1'b1, "rst_bus", dht_data, 1);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    run_frame(32'h37001905, 40'h3700190555);
    for (int n = 0; n < 2; n++) begin
      repeat (10) @(posedge clk);
      fd0 = fd_count;
      host_start($urandom_range(20, START_MIN - 3));
      repeat (200 * DIV) @(posedge clk);
      check(fd_count == fd0, "short_start", fd_count - fd0, 0);
    end
    run_frame(32'hFF000000, 40'hFF000000FF);
    run_frame(32'hFFFF0102, 40'hFFFF010201);
    begin_frame(32'h12345678, fd0);
    t = 0;
    while (runs_len.size() < 27 && t < 20000) begin @(negedge clk); t++; end
    check(runs_len.size() >= 27 && dht_data === 1'b0, "bit12_low", dht_data, 0);
    #2 reset_n = 1'b0;
    in_frame = 1'b0;
    #1;
    check(dht_data === 1'b1, "rst_mid_bus", dht_data, 1);
    check(busy === 1'b0, "rst_mid_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (200) @(posedge clk);
    check(fd_count == fd0, "rst_mid_no_done", fd_count - fd0, 0);
    run_frame(32'h37001905, 40'h3700190555);
    for (int n = 0; n < 2; n++) begin
      p = $urandom;
      run_frame(p, model_word(p, cksum_err));
    end
`ifdef DHT_RESP_CKSUM_ERR_EN
    cksum_err = 1'b1;
    run_frame(32'h37001905, 40'h37001905AA);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
Single-wire DHT11 sensor emulator: the responder side of the DHT11 protocol that our sensor interfaces initiate. It watches the bus for a host start pulse. It then answers with the standard response preamble, 40 data bits (4 payload bytes plus checksum) and an end pulse. Used on-board as a loopback target for the sensor interfaces and as a bench stand-in for real sensors.

Parameters:
CLK_FREQ, 12000000, system clock in Hz; microsecond tick = CLK_FREQ/1000000 cycles (12).
START_MIN_US, 18000, minimum host low pulse, in µs, accepted as a valid start.
RESP_DELAY_US, 30, high gap after host release before the responder drives low.

Ports:
clk  input  1  system clock (12 MHz)
reset_n  input  1  asynchronous active-low reset
dht_data  inout  1  open-drain DHT bus; driven 0 when low is required, else high-Z (external pull-up)
payload  input  32  [31:24] RH int, [23:16] RH dec, [15:8] T int, [7:0] T dec
busy  output  1  high from response start to end of final low pulse
frame_done  output  1  one-cycle pulse when a frame completes and the bus is released
debug_state  output  4  current FSM state encoding

Behaviour:
- Reset values:
  - busy=0, frame_done=0, bus released (high-Z).
  - FSM=IDLE; all counters and the shift register cleared.
  - Reset asserted mid-frame releases the bus on the same edge. The partial frame is abandoned with no frame_done.
- Input path: dht_data passes through a 2-flop synchronizer (din_s). All decisions use din_s, so add 2 cycles of latency.
- Timebase:
  - Prescaler produces a 1-cycle us_tick every CLK_FREQ/1e6 cycles.
  - 15-bit us_cnt counts ticks and saturates at max.
  - us_cnt and the prescaler are cleared on every state change.
- States:
  - IDLE: bus released. din_s=0 → START_LOW.
  - START_LOW: count µs while din_s=0.
    - On din_s=1: if us_cnt>=START_MIN_US → WAIT_REL, else → IDLE (glitch/short pulse ignored, no output).
  - WAIT_REL: bus released.
    - After RESP_DELAY_US: latch payload into a 40-bit shift register {payload, checksum} and set busy=1 → RESP_LOW.
    - checksum = (payload[31:24]+payload[23:16]+payload[15:8]+payload[7:0]) mod 256 (8-bit wrap).
    - payload changes after the latch do not affect the frame in flight.
  - RESP_LOW: drive 0 for 80 µs → RESP_HIGH.
  - RESP_HIGH: release for 80 µs → BIT_LOW.
  - BIT_LOW: drive 0 for 50 µs → BIT_HIGH.
  - BIT_HIGH: release for 26 µs if current MSB=0, 70 µs if 1.
    - Then shift left and increment the 6-bit bit_cnt.
    - bit_cnt==40 → END_LOW, else → BIT_LOW.
  - END_LOW: drive 0 for 50 µs, then release, set busy=0, pulse frame_done → IDLE.
- Bit/byte order: MSB first; payload[31:24] first, checksum last.
- A start pulse arriving while busy=1 is ignored; the FSM never leaves the frame early except on reset.
- The bus must read high in IDLE after frame_done before a new start is recognised. A low already present when IDLE is entered is timed from entry.
- Duration tolerance: each phase is exact to within one µs tick (±12 cycles at default).

Optional Feature:
DHT_RESP_CKSUM_ERR_EN
- Defined: adds input port cksum_err (1 bit), sampled at payload latch. If 1, the transmitted checksum is bitwise-inverted, for exercising the sensor interface's checksum-reject path.
- Undefined: the port is absent and the checksum is always correct.

Test Plan:
- Valid read:
  - Stimulus: payload=0x37001905; host drives low 18 ms, releases.
  - Response: after 30 µs, 80 µs low / 80 µs high; 40 bits decode to 0x37,0x00,0x19,0x05,0x55.
  - Completion: 50 µs end low, then frame_done pulse once; busy high across the whole frame.
- Short start: host low 5 ms → responder never drives the bus, busy stays 0, returns to IDLE.
- Bit timing: payload=0xFF000000 → first 8 high phases 70 µs, next 24 high phases 26 µs; checksum 0xFF all 70 µs.
- Checksum wrap: payload=0xFFFF0102 → checksum byte 0x01.
- Mid-frame reset and latch isolation:
  - Reset asserted during bit 12 → bus high-Z immediately, busy=0, no frame_done.
  - Following valid start → full correct frame.
  - Changing payload during a frame does not alter transmitted bytes.
- DHT_RESP_CKSUM_ERR_EN defined, cksum_err=1, payload=0x37001905 → checksum byte 0xAA; the paired sensor interface does not assert data_valid.
